// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the divider.
// Provides the divider FSM state encoding, the default iteration count
// and the {remainder, quotient} result payload.
package cpu_defs;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // HI holds the remainder, LO holds the quotient
  typedef struct packed {
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
  } div_result_t;

endpackage

// File: rtl/div_abs_fix.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to restore the sign of the quotient and remainder.
//   value   : input word
//   neg     : 1 negates value, 0 passes it through
//   fixed_c : combinational result
module div_abs_fix
  import cpu_defs::*;
(
  input  logic [XLEN-1:0] value,
  input  logic            neg,
  output logic [XLEN-1:0] fixed_c
);

  assign fixed_c = neg ? ((~value) + XLEN'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per clock.
//   clk, resetn : clock, synchronous active-low reset
//   start       : E-stage divide present (held while stalled)
//   signed_div  : 1 = DIV, 0 = DIVU
//   opa, opb    : dividend, divisor
//   annul       : abort the operation in flight
//   stall       : combinational busy to the hazard unit
//   ready       : one-cycle pulse when result is valid
//   result      : {remainder, quotient}, held until the next completion
module div_unit
  import cpu_defs::*;
#(
  parameter int unsigned DIV_CYCLES = cpu_defs::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        annul,
  output logic        stall,
  output logic        ready,
  output logic [63:0] result
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       rq_q, rq_d;       // {partial remainder, quotient/dividend}
  logic [XLEN-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  div_result_t       result_q, result_d;
  logic              ready_q, ready_d;

  logic [XLEN-1:0]   opa_abs, opb_abs;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              take;
  logic [63:0]       rq_step;

  // Operand magnitudes (only signed divides take the absolute value)
  div_abs_fix u_abs_a (.value(opa), .neg(signed_div & opa[31]), .fixed_c(opa_abs));
  div_abs_fix u_abs_b (.value(opb), .neg(signed_div & opb[31]), .fixed_c(opb_abs));

  // One restoring step: shift left, subtract divisor if it fits
  always_comb begin
    rem_sh  = rq_q[63:31];
    take    = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rq_q[62:31] - dvs_q;
    rq_step = take ? {rem_sub, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
  end

  // Sign correction of the final step's outcome
  div_abs_fix u_fix_q (.value(rq_step[31:0]),  .neg(quo_neg_q), .fixed_c(quo_fix));
  div_abs_fix u_fix_r (.value(rq_step[63:32]), .neg(rem_neg_q), .fixed_c(rem_fix));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rq_q      <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rq_q      <= rq_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rq_d      = rq_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          dvs_d     = opb_abs;
          rq_d      = {32'd0, opa_abs};
          quo_neg_d = signed_div & (opa[31] ^ opb[31]);
          rem_neg_d = signed_div & opa[31];
          cnt_d     = '0;
          if (opb == 32'd0) begin
            // Divide by zero bypasses the iteration entirely
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = '{rem: opa, quo: 32'hFFFF_FFFF};
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rq_d  = rq_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = '{rem: rem_fix, quo: quo_fix};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush overrides everything and leaves the result untouched
    if (annul) begin
      state_d  = IDLE;
      cnt_d    = '0;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  assign stall  = start & ~ready_q & ~annul;
  assign ready  = ready_q;
  assign result = result_q;

endmodule
